// File: rtl/starflux_pkg.sv
// rtl/starflux_pkg.sv - shared screen geometry, colours and draw-state type
package starflux_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam int X_W = 8;
    localparam int Y_W = 7;

    localparam logic [2:0] BLACK   = 3'b000;
    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] CYAN    = 3'b011;
    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] YELLOW  = 3'b110;
    localparam logic [2:0] WHITE   = 3'b111;

    typedef enum logic [1:0] {
        DS_IDLE  = 2'd0,
        DS_ERASE = 2'd1,
        DS_DRAW  = 2'd2
    } draw_state_t;

endpackage

// File: rtl/enemy_sprite_rom.sv
// rtl/enemy_sprite_rom.sv - combinational enemy sprite bitmap (checkerboard), indexed by row/column
module enemy_sprite_rom #(
    parameter int SPRITE_W = 8,
    parameter int SPRITE_H = 4
) (
    input  logic [3:0] px,
    input  logic [2:0] py,
    output logic       pixel_on
);

    // Row r, bit c: 1 = opaque sprite pixel, 0 = transparent. Row 0 is the rightmost entry.
    localparam logic [7:0][15:0] BITMAP = {
        16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA,
        16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA
    };

    // Pixels outside the configured sprite area are always transparent
    always_comb begin
        pixel_on = 1'b0;
        if (({1'b0, px} < 5'(SPRITE_W)) && ({1'b0, py} < 4'(SPRITE_H)))
            pixel_on = BITMAP[py][px];
    end

endmodule

// File: rtl/enemy_sprite_drawer.sv
// rtl/enemy_sprite_drawer.sv - erase/redraw enemy sprite into VGA frame buffer; ENEMY_SPRITE_ROM_EN selects bitmap sprite
module enemy_sprite_drawer
    import starflux_pkg::*;
#(
    parameter int         SPRITE_W      = 8,
    parameter int         SPRITE_H      = 4,
    parameter logic [6:0] ENEMY_Y       = 7'd8,
    parameter logic [2:0] SPRITE_COLOUR = RED,
    parameter logic [2:0] BG_COLOUR     = BLACK
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic [X_W-1:0] x_pos,
    output logic [X_W-1:0] vga_x,
    output logic [Y_W-1:0] vga_y,
    output logic [2:0]     vga_colour,
    output logic           vga_plot,
    output logic           busy
);

    localparam logic [3:0] PX_LAST = 4'(SPRITE_W - 1);
    localparam logic [2:0] PY_LAST = 3'(SPRITE_H - 1);

    draw_state_t    state;
    logic [X_W-1:0] drawn_x;
    logic           drawn_valid;
    logic [X_W-1:0] target_x;
    logic [3:0]     px;
    logic [2:0]     py;

    logic [X_W-1:0] scan_base;
    logic [X_W:0]   pix_x;
    logic           pix_on_screen;
    logic           draw_on;
    logic [2:0]     pix_colour;
    logic           pix_plot;

`ifdef ENEMY_SPRITE_ROM_EN
    enemy_sprite_rom #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H)
    ) u_rom (
        .px       (px),
        .py       (py),
        .pixel_on (draw_on)
    );
`else
    assign draw_on = 1'b1;
`endif

    // Current scan pixel: x is widened so positions past the right edge are clipped, not wrapped
    always_comb begin
        scan_base     = (state == DS_ERASE) ? drawn_x : target_x;
        pix_x         = {1'b0, scan_base} + {5'b0, px};
        pix_on_screen = (pix_x < 9'(SCREEN_W));
        pix_colour    = (state == DS_ERASE) ? BG_COLOUR : SPRITE_COLOUR;
        pix_plot      = pix_on_screen && ((state == DS_ERASE) || draw_on);
    end

    // Update sequencer: wait for a new position, erase the old rectangle, draw the new one
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= DS_IDLE;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= BG_COLOUR;
            vga_plot    <= 1'b0;
            busy        <= 1'b0;
            drawn_x     <= '0;
            drawn_valid <= 1'b0;
            target_x    <= '0;
            px          <= '0;
            py          <= '0;
        end else begin
            case (state)
                DS_IDLE: begin
                    vga_plot <= 1'b0;
                    if (!drawn_valid || (x_pos != drawn_x)) begin
                        target_x <= x_pos;
                        px       <= '0;
                        py       <= '0;
                        busy     <= 1'b1;
                        // Nothing on screen yet after reset, so skip straight to drawing
                        state    <= drawn_valid ? DS_ERASE : DS_DRAW;
                    end
                end
                DS_ERASE, DS_DRAW: begin
                    vga_x      <= pix_x[X_W-1:0];
                    vga_y      <= ENEMY_Y + {4'b0, py};
                    vga_colour <= pix_colour;
                    vga_plot   <= pix_plot;
                    if (px == PX_LAST) begin
                        px <= '0;
                        if (py == PY_LAST) begin
                            py <= '0;
                            if (state == DS_ERASE) begin
                                state <= DS_DRAW;
                            end else begin
                                drawn_x     <= target_x;
                                drawn_valid <= 1'b1;
                                busy        <= 1'b0;
                                state       <= DS_IDLE;
                            end
                        end else begin
                            py <= py + 3'd1;
                        end
                    end else begin
                        px <= px + 4'd1;
                    end
                end
                default: begin
                    state    <= DS_IDLE;
                    busy     <= 1'b0;
                    vga_plot <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enemy_sprite_drawer.sv
// tb/tb_enemy_sprite_drawer.sv - scoreboard bench for enemy_sprite_drawer
module tb_enemy_sprite_drawer;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int EY = 8;
    localparam int RED_C = 4;
    localparam int BG_C  = 0;

    logic       clock = 1'b0;
    logic       resetn;
    logic [7:0] x_pos;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;

    always #10 clock = ~clock;

    enemy_sprite_drawer dut (
        .clock      (clock),
        .resetn     (resetn),
        .x_pos      (x_pos),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy)
    );

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    typedef struct {
        int new_x;
        int busy_cycles;
        int solid_plots;
    } vec_t;

    pix_t exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   busy_cnt  = 0;
    int   plot_cnt  = 0;
    int   model_x   = 0;
    bit   model_valid = 1'b0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Scoreboard sampling at the falling edge, away from the active edge
    task automatic sample();
        pix_t p;
        if (busy === 1'b1) busy_cnt++;
        if (vga_plot === 1'b1) begin
            plot_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_plot got x=%0d y=%0d c=%0d exp=none", vga_x, vga_y, vga_colour);
            end else begin
                p = exp_q.pop_front();
                if (int'(vga_x) != p.x || int'(vga_y) != p.y || int'(vga_colour) != p.c) begin
                    failures++;
                    $display("FAIL pixel got x=%0d y=%0d c=%0d exp x=%0d y=%0d c=%0d",
                             vga_x, vga_y, vga_colour, p.x, p.y, p.c);
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clock);
        sample();
        #1;
    endtask

    function automatic bit rom_on(input int px, input int py);
`ifdef ENEMY_SPRITE_ROM_EN
        return ((px % 2) != (py % 2));
`else
        return 1'b1;
`endif
    endfunction

    task automatic push_scan(input int base, input int colour, input bit use_rom);
        for (int py = 0; py < H; py++)
            for (int px = 0; px < W; px++)
                if ((base + px) < 160 && (!use_rom || rom_on(px, py)))
                    exp_q.push_back('{base + px, EY + py, colour});
    endtask

    task automatic push_update(input int new_x);
        if (model_valid) push_scan(model_x, BG_C, 1'b0);
        push_scan(new_x, RED_C, 1'b1);
        model_x     = new_x;
        model_valid = 1'b1;
    endtask

    task automatic wait_busy(input bit level, input int budget, input string name);
        int n = 0;
        while (busy !== level && n < budget) begin
            step();
            n++;
        end
        check(name, int'(busy), int'(level));
    endtask

    vec_t vecs[6];

    initial begin
        int b0, p0, q0, exp_plots;

        vecs[0] = '{11,  64, 64};
        vecs[1] = '{155, 64, 52};
        vecs[2] = '{160, 64, 20};
        vecs[3] = '{0,   64, 32};
        vecs[4] = '{152, 64, 64};
        vecs[5] = '{153, 64, 60};

        resetn = 1'b0;
        x_pos  = 8'd10;
        repeat (3) step();
        check("reset_plot",   int'(vga_plot),   0);
        check("reset_busy",   int'(busy),       0);
        check("reset_x",      int'(vga_x),      0);
        check("reset_y",      int'(vga_y),      0);
        check("reset_colour", int'(vga_colour), BG_C);

        // First draw after reset: no erase, W*H cycles
        push_update(10);
        b0 = busy_cnt; p0 = plot_cnt; q0 = exp_q.size();
        resetn = 1'b1;
        step();
        check("busy_after_1", int'(busy), 1);
        wait_busy(1'b0, 200, "first_draw_done");
        repeat (3) step();
        check("first_busy_cycles", busy_cnt - b0, W * H);
        check("first_plots",       plot_cnt - p0, q0);
        check("first_queue_empty", exp_q.size(),  0);

        for (int i = 0; i < 6; i++) begin
            push_update(vecs[i].new_x);
            b0 = busy_cnt; p0 = plot_cnt;
`ifdef ENEMY_SPRITE_ROM_EN
            exp_plots = exp_q.size();
`else
            exp_plots = vecs[i].solid_plots;
`endif
            x_pos = 8'(vecs[i].new_x);
            wait_busy(1'b1, 10,  "vec_start");
            wait_busy(1'b0, 200, "vec_done");
            repeat (3) step();
            check($sformatf("vec%0d_busy_cycles", i), busy_cnt - b0, vecs[i].busy_cycles);
            check($sformatf("vec%0d_plots", i),       plot_cnt - p0, exp_plots);
            check($sformatf("vec%0d_queue", i),       exp_q.size(),  0);
        end

        // Position changes while busy: only the latest value is drawn afterwards
        push_update(20);
        push_update(22);
        b0 = busy_cnt; p0 = plot_cnt; q0 = exp_q.size();
        x_pos = 8'd20;
        wait_busy(1'b1, 10, "mid_start");
        repeat (5) step();
        x_pos = 8'd21;
        repeat (5) step();
        x_pos = 8'd22;
        wait_busy(1'b0, 200, "mid_first_done");
        wait_busy(1'b1, 10,  "mid_second_start");
        wait_busy(1'b0, 200, "mid_second_done");
        repeat (3) step();
        check("mid_busy_cycles", busy_cnt - b0, 128);
        check("mid_plots",       plot_cnt - p0, q0);
        check("mid_queue",       exp_q.size(),  0);

        // Unchanged position: no activity
        b0 = busy_cnt; p0 = plot_cnt;
        repeat (20) step();
        check("idle_busy",  busy_cnt - b0, 0);
        check("idle_plots", plot_cnt - p0, 0);

        // Reset in the middle of DRAW
        push_update(50);
        x_pos = 8'd50;
        wait_busy(1'b1, 10, "abort_start");
        repeat (40) step();
        #2;
        resetn = 1'b0;
        #1;
        check("abort_plot",   int'(vga_plot),   0);
        check("abort_busy",   int'(busy),       0);
        check("abort_x",      int'(vga_x),      0);
        check("abort_y",      int'(vga_y),      0);
        check("abort_colour", int'(vga_colour), BG_C);
        exp_q.delete();
        model_valid = 1'b0;
        repeat (3) step();

        push_update(50);
        b0 = busy_cnt; p0 = plot_cnt; q0 = exp_q.size();
        resetn = 1'b1;
        step();
        check("redraw_busy_after_1", int'(busy), 1);
        wait_busy(1'b0, 200, "redraw_done");
        repeat (3) step();
        check("redraw_busy_cycles", busy_cnt - b0, W * H);
        check("redraw_plots",       plot_cnt - p0, q0);
        check("redraw_queue",       exp_q.size(),  0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
